// File: rtl/risc_pipe.sv
// 5-stage in-order MIPS-like core with internal unified word memory and 32x32 register file.
// EX-stage forwarding; taken branches squash IF/ID and ID/EX; HLT stops fetch and sets halted.
module risc_pipe #(
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned RIDX_W = 5;
   localparam int unsigned OP_W   = 6;

   localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
   localparam logic [OP_W-1:0] OP_AND   = 6'b000010;
   localparam logic [OP_W-1:0] OP_OR    = 6'b000011;
   localparam logic [OP_W-1:0] OP_SLT   = 6'b000100;
   localparam logic [OP_W-1:0] OP_MUL   = 6'b000101;
   localparam logic [OP_W-1:0] OP_LW    = 6'b001000;
   localparam logic [OP_W-1:0] OP_SW    = 6'b001001;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_SUBI  = 6'b001011;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_BNEQZ = 6'b001101;
   localparam logic [OP_W-1:0] OP_BEQZ  = 6'b001110;
   localparam logic [OP_W-1:0] OP_HLT   = 6'b111111;
   localparam logic [OP_W-1:0] OP_NOP   = 6'b111100;
   localparam logic [XLEN-1:0] NOP_IR   = {OP_NOP, 26'd0};

   logic [XLEN-1:0] mem  [MEM_DEPTH];
   logic [XLEN-1:0] regs [NREG];

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic              stop_q, stop_d;

   logic [XLEN-1:0]   if_id_ir_q, if_id_ir_d;
   logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;

   logic [OP_W-1:0]   id_ex_op_q, id_ex_op_d;
   logic              id_ex_we_q, id_ex_we_d, id_ex_ld_q, id_ex_ld_d;
   logic              id_ex_st_q, id_ex_st_d, id_ex_hlt_q, id_ex_hlt_d;
   logic [RIDX_W-1:0] id_ex_dest_q, id_ex_dest_d, id_ex_rs_q, id_ex_rs_d, id_ex_rt_q, id_ex_rt_d;
   logic [XLEN-1:0]   id_ex_a_q, id_ex_a_d, id_ex_b_q, id_ex_b_d, id_ex_imm_q, id_ex_imm_d;
   logic [ADDR_W-1:0] id_ex_pc_q, id_ex_pc_d;

   logic              ex_mem_we_q, ex_mem_we_d, ex_mem_ld_q, ex_mem_ld_d;
   logic              ex_mem_st_q, ex_mem_st_d, ex_mem_hlt_q, ex_mem_hlt_d;
   logic [RIDX_W-1:0] ex_mem_dest_q, ex_mem_dest_d;
   logic [XLEN-1:0]   ex_mem_alu_q, ex_mem_alu_d, ex_mem_sd_q, ex_mem_sd_d;

   logic              mem_wb_we_q, mem_wb_we_d, mem_wb_hlt_q, mem_wb_hlt_d;
   logic [RIDX_W-1:0] mem_wb_dest_q, mem_wb_dest_d;
   logic [XLEN-1:0]   mem_wb_res_q, mem_wb_res_d;

   logic [OP_W-1:0]   id_op;
   logic [RIDX_W-1:0] id_rs, id_rt, id_rd, id_dest;
   logic [XLEN-1:0]   id_imm, id_a, id_b;
   logic              id_rr, id_ri, id_ld, id_st, id_hlt, id_we;
   logic              wb_we;

   logic [XLEN-1:0]   ex_a, ex_b, ex_alu;
   logic              ex_taken;
   logic [ADDR_W-1:0] ex_target;

   logic [XLEN-1:0]   mem_rdata;
   logic              mem_we;

   assign pc     = pc_q;
   assign halted = halted_q;

   // ID: decode and register read with write-through of the same-edge WB write
   always_comb begin
      id_op   = if_id_ir_q[31:26];
      id_rs   = if_id_ir_q[25:21];
      id_rt   = if_id_ir_q[20:16];
      id_rd   = if_id_ir_q[15:11];
      id_imm  = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
      id_rr   = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
      id_ri   = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
      id_ld   = (id_op == OP_LW);
      id_st   = (id_op == OP_SW);
      id_hlt  = (id_op == OP_HLT);
      id_we   = id_rr | id_ri | id_ld;
      id_dest = id_rr ? id_rd : id_rt;
      wb_we   = mem_wb_we_q && !halted_q && (mem_wb_dest_q != '0);
      id_a    = regs[id_rs];
      id_b    = regs[id_rt];
      if (wb_we && (mem_wb_dest_q == id_rs)) id_a = mem_wb_res_q;
      if (wb_we && (mem_wb_dest_q == id_rt)) id_b = mem_wb_res_q;
      if (id_rs == '0) id_a = '0;
      if (id_rt == '0) id_b = '0;
   end

   // EX: operand forwarding (loads are not forwarded from EX/MEM), ALU and branch resolution
   always_comb begin
      ex_a = id_ex_a_q;
      ex_b = id_ex_b_q;
      if (ex_mem_we_q && !ex_mem_ld_q && (ex_mem_dest_q != '0) && (ex_mem_dest_q == id_ex_rs_q))
         ex_a = ex_mem_alu_q;
      else if (mem_wb_we_q && (mem_wb_dest_q != '0) && (mem_wb_dest_q == id_ex_rs_q))
         ex_a = mem_wb_res_q;
      if (ex_mem_we_q && !ex_mem_ld_q && (ex_mem_dest_q != '0) && (ex_mem_dest_q == id_ex_rt_q))
         ex_b = ex_mem_alu_q;
      else if (mem_wb_we_q && (mem_wb_dest_q != '0) && (mem_wb_dest_q == id_ex_rt_q))
         ex_b = mem_wb_res_q;

      ex_alu = '0;
      case (id_ex_op_q)
         OP_ADD:                  ex_alu = ex_a + ex_b;
         OP_SUB:                  ex_alu = ex_a - ex_b;
         OP_AND:                  ex_alu = ex_a & ex_b;
         OP_OR:                   ex_alu = ex_a | ex_b;
         OP_SLT:                  ex_alu = XLEN'($signed(ex_a) < $signed(ex_b));
         OP_MUL:                  ex_alu = ex_a * ex_b;
         OP_ADDI, OP_LW, OP_SW:   ex_alu = ex_a + id_ex_imm_q;
         OP_SUBI:                 ex_alu = ex_a - id_ex_imm_q;
         OP_SLTI:                 ex_alu = XLEN'($signed(ex_a) < $signed(id_ex_imm_q));
         default:                 ex_alu = '0;
      endcase

      ex_taken  = ((id_ex_op_q == OP_BNEQZ) && (ex_a != '0)) ||
                  ((id_ex_op_q == OP_BEQZ)  && (ex_a == '0));
      ex_target = id_ex_pc_q + ADDR_W'(1) + id_ex_imm_q[ADDR_W-1:0];
   end

   assign mem_rdata = mem[ex_mem_alu_q[ADDR_W-1:0]];
   assign mem_we    = ex_mem_st_q && !halted_q;

   // Next state for fetch and all pipeline registers
   always_comb begin
      pc_d       = pc_q;
      halted_d   = halted_q | mem_wb_hlt_q;
      stop_d     = stop_q | (id_hlt && !ex_taken);
      if_id_ir_d = NOP_IR;
      if_id_pc_d = pc_q;

      id_ex_op_d   = id_op;
      id_ex_we_d   = id_we;
      id_ex_ld_d   = id_ld;
      id_ex_st_d   = id_st;
      id_ex_hlt_d  = id_hlt;
      id_ex_dest_d = id_dest;
      id_ex_rs_d   = id_rs;
      id_ex_rt_d   = id_rt;
      id_ex_a_d    = id_a;
      id_ex_b_d    = id_b;
      id_ex_imm_d  = id_imm;
      id_ex_pc_d   = if_id_pc_q;

      if (ex_taken) begin
         pc_d        = ex_target;
         id_ex_op_d  = OP_NOP;
         id_ex_we_d  = 1'b0;
         id_ex_ld_d  = 1'b0;
         id_ex_st_d  = 1'b0;
         id_ex_hlt_d = 1'b0;
      end else if (!(id_hlt || stop_q)) begin
         pc_d       = pc_q + ADDR_W'(1);
         if_id_ir_d = mem[pc_q];
      end

      ex_mem_we_d   = id_ex_we_q;
      ex_mem_ld_d   = id_ex_ld_q;
      ex_mem_st_d   = id_ex_st_q;
      ex_mem_hlt_d  = id_ex_hlt_q;
      ex_mem_dest_d = id_ex_dest_q;
      ex_mem_alu_d  = ex_alu;
      ex_mem_sd_d   = ex_b;

      mem_wb_we_d   = ex_mem_we_q;
      mem_wb_hlt_d  = ex_mem_hlt_q;
      mem_wb_dest_d = ex_mem_dest_q;
      mem_wb_res_d  = ex_mem_ld_q ? mem_rdata : ex_mem_alu_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= '0;
         halted_q      <= 1'b0;
         stop_q        <= 1'b0;
         if_id_ir_q    <= NOP_IR;
         if_id_pc_q    <= '0;
         id_ex_op_q    <= OP_NOP;
         id_ex_we_q    <= 1'b0;
         id_ex_ld_q    <= 1'b0;
         id_ex_st_q    <= 1'b0;
         id_ex_hlt_q   <= 1'b0;
         id_ex_dest_q  <= '0;
         id_ex_rs_q    <= '0;
         id_ex_rt_q    <= '0;
         id_ex_a_q     <= '0;
         id_ex_b_q     <= '0;
         id_ex_imm_q   <= '0;
         id_ex_pc_q    <= '0;
         ex_mem_we_q   <= 1'b0;
         ex_mem_ld_q   <= 1'b0;
         ex_mem_st_q   <= 1'b0;
         ex_mem_hlt_q  <= 1'b0;
         ex_mem_dest_q <= '0;
         ex_mem_alu_q  <= '0;
         ex_mem_sd_q   <= '0;
         mem_wb_we_q   <= 1'b0;
         mem_wb_hlt_q  <= 1'b0;
         mem_wb_dest_q <= '0;
         mem_wb_res_q  <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         pc_q          <= pc_d;
         halted_q      <= halted_d;
         stop_q        <= stop_d;
         if_id_ir_q    <= if_id_ir_d;
         if_id_pc_q    <= if_id_pc_d;
         id_ex_op_q    <= id_ex_op_d;
         id_ex_we_q    <= id_ex_we_d;
         id_ex_ld_q    <= id_ex_ld_d;
         id_ex_st_q    <= id_ex_st_d;
         id_ex_hlt_q   <= id_ex_hlt_d;
         id_ex_dest_q  <= id_ex_dest_d;
         id_ex_rs_q    <= id_ex_rs_d;
         id_ex_rt_q    <= id_ex_rt_d;
         id_ex_a_q     <= id_ex_a_d;
         id_ex_b_q     <= id_ex_b_d;
         id_ex_imm_q   <= id_ex_imm_d;
         id_ex_pc_q    <= id_ex_pc_d;
         ex_mem_we_q   <= ex_mem_we_d;
         ex_mem_ld_q   <= ex_mem_ld_d;
         ex_mem_st_q   <= ex_mem_st_d;
         ex_mem_hlt_q  <= ex_mem_hlt_d;
         ex_mem_dest_q <= ex_mem_dest_d;
         ex_mem_alu_q  <= ex_mem_alu_d;
         ex_mem_sd_q   <= ex_mem_sd_d;
         mem_wb_we_q   <= mem_wb_we_d;
         mem_wb_hlt_q  <= mem_wb_hlt_d;
         mem_wb_dest_q <= mem_wb_dest_d;
         mem_wb_res_q  <= mem_wb_res_d;
         if (wb_we) regs[mem_wb_dest_q] <= mem_wb_res_q;
      end
   end

   // Memory contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[ex_mem_alu_q[ADDR_W-1:0]] <= ex_mem_sd_q;
   end

endmodule

// File: tb/tb_risc_pipe.sv
// Bench for risc_pipe: an instruction-level model predicts final state, fetch pc per edge and
// the halt edge; directed programs with hand-computed results pin the model.
module tb_risc_pipe;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
   localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
   localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
   localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
   localparam logic [31:0] HLT_W = 32'hFC000000;
   localparam logic [31:0] NOP_W = 32'hF0000000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       halted;
   logic [9:0] pc;

   risc_pipe #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .halted(halted), .pc(pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] prog [$];
   logic [31:0] mmem [1024];
   logic [31:0] mregs [32];
   int unsigned pcq [$];
   int          model_h;
   int          subi_cnt;

   function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 1024; i++) begin
         dut.mem[i] = '0;
         mmem[i]    = '0;
      end
      for (int i = 0; i < prog.size(); i++) begin
         dut.mem[i] = prog[i];
         mmem[i]    = prog[i];
      end
   endtask

   task automatic poke(input int addr, input logic [31:0] val);
      dut.mem[addr] = val;
      mmem[addr]    = val;
   endtask

   function automatic void mwr(input int r, input logic [31:0] v);
      if (r != 0) mregs[r] = v;
   endfunction

   // Sequential ISA execution; fetch timeline: one fetch per edge, +2 wrong-path edges per taken branch
   task automatic model_run();
      int unsigned p;
      logic [31:0] ir, a, b, imm;
      int rs, rt, rd;
      bit done;
      for (int r = 0; r < 32; r++) mregs[r] = '0;
      pcq = {};
      pcq.push_back(0);
      model_h = -1;
      subi_cnt = 0;
      p = 0;
      done = 0;
      for (int step = 0; step < 4000 && !done; step++) begin
         ir  = mmem[p];
         rs  = int'(ir[25:21]);
         rt  = int'(ir[20:16]);
         rd  = int'(ir[15:11]);
         imm = {{16{ir[15]}}, ir[15:0]};
         a   = mregs[rs];
         b   = mregs[rt];
         pcq.push_back((p + 1) % 1024);
         case (ir[31:26])
            ADD:   mwr(rd, a + b);
            SUB:   mwr(rd, a - b);
            AND_:  mwr(rd, a & b);
            OR_:   mwr(rd, a | b);
            SLT:   mwr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            MUL:   mwr(rd, a * b);
            ADDI:  mwr(rt, a + imm);
            SUBI:  begin mwr(rt, a - imm); subi_cnt++; end
            SLTI:  mwr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
            LW:    mwr(rt, mmem[(a + imm) & 32'h3FF]);
            SW:    mmem[(a + imm) & 32'h3FF] = b;
            6'b111111: begin
               model_h = pcq.size() - 1 + 4;
               done = 1;
            end
            default: ;
         endcase
         if (!done) begin
            if (((ir[31:26] == BNEQZ) && (a != 0)) || ((ir[31:26] == BEQZ) && (a == 0))) begin
               pcq.push_back((p + 2) % 1024);
               p = (p + 1 + imm) % 1024;
               pcq.push_back(p);
            end else begin
               p = (p + 1) % 1024;
            end
         end
      end
   endtask

   // Per-edge compare of pc and halted against the model timeline
   task automatic run_edges(input string tag, input int last_e);
      int unsigned exp_pc;
      for (int e = 1; e <= last_e; e++) begin
         @(negedge clk);
         exp_pc = (e < pcq.size()) ? pcq[e] : pcq[pcq.size() - 1];
         chk($sformatf("%s pc@%0d", tag, e), 32'(pc), exp_pc);
         chk($sformatf("%s halted@%0d", tag, e), 32'(halted),
             (model_h >= 0 && e >= model_h) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic check_final(input string tag);
      for (int r = 0; r < 32; r++) chk($sformatf("%s R%0d", tag, r), dut.regs[r], mregs[r]);
      for (int i = 0; i < 128; i++) chk($sformatf("%s mem[%0d]", tag, i), dut.mem[i], mmem[i]);
   endtask

   task automatic run_test(input string tag);
      rst_n = 1'b0;
      #1;
      load_prog();
      model_run();
      if (model_h < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s model: program never reaches HLT", tag);
      end
      @(negedge clk);
      chk({tag, " reset pc"}, 32'(pc), 32'd0);
      chk({tag, " reset halted"}, 32'(halted), 32'd0);
      rst_n = 1'b1;
      run_edges(tag, (model_h >= 0) ? model_h + 3 : 200);
      check_final(tag);
   endtask

   task automatic load_t1();
      prog = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
   endtask

   initial begin
      // 1: straight-line program
      load_t1();
      run_test("t1");
      chk("t1 halt edge", 32'(model_h), 32'd13);
      chk("t1 R1", dut.regs[1], 32'd10);
      chk("t1 R2", dut.regs[2], 32'd20);
      chk("t1 R3", dut.regs[3], 32'd25);
      chk("t1 R4", dut.regs[4], 32'd30);
      chk("t1 R5", dut.regs[5], 32'd55);

      // 2: back-to-back dependencies
      prog = {ri(ADDI, 1, 0, 5), rr(ADD, 2, 1, 1), rr(SUB, 3, 2, 1), HLT_W};
      run_test("t2");
      chk("t2 R2", dut.regs[2], 32'd10);
      chk("t2 R3", dut.regs[3], 32'd5);

      // 3: load, NOP, dependent add, store
      prog = {ri(LW, 2, 0, 120), NOP_W, ri(ADDI, 3, 2, 45), ri(SW, 3, 0, 121), HLT_W};
      rst_n = 1'b0;
      #1;
      load_prog();
      poke(120, 32'd85);
      prog = {};
      for (int i = 0; i < 128; i++) prog.push_back(dut.mem[i]);
      run_test("t3");
      chk("t3 R3", dut.regs[3], 32'd130);
      chk("t3 mem121", dut.mem[121], 32'd130);

      // 4a: taken branch squashes two following instructions
      prog = {ri(BEQZ, 0, 0, 2), ri(ADDI, 1, 0, 1), ri(ADDI, 2, 0, 2), ri(ADDI, 3, 0, 3), HLT_W};
      run_test("t4a");
      chk("t4a halt edge", 32'(model_h), 32'd9);
      chk("t4a R1", dut.regs[1], 32'd0);
      chk("t4a R2", dut.regs[2], 32'd0);
      chk("t4a R3", dut.regs[3], 32'd3);

      // 4b: countdown loop
      prog = {ri(ADDI, 1, 0, 3), ri(SUBI, 1, 1, 1), ri(BNEQZ, 0, 1, -2), HLT_W};
      run_test("t4b");
      chk("t4b R1", dut.regs[1], 32'd0);
      chk("t4b loop count", 32'(subi_cnt), 32'd3);

      // 5a: nothing after HLT commits
      prog = {HLT_W, ri(ADDI, 6, 0, 7)};
      run_test("t5a");
      chk("t5a R6", dut.regs[6], 32'd0);
      chk("t5a pc", 32'(pc), 32'd1);
      chk("t5a halted", 32'(halted), 32'd1);

      // 5b: R0 write discarded, not forwarded
      prog = {ri(ADDI, 0, 0, 9), ri(ADDI, 7, 0, 4), rr(ADD, 8, 0, 0), HLT_W};
      run_test("t5b");
      chk("t5b R0", dut.regs[0], 32'd0);
      chk("t5b R7", dut.regs[7], 32'd4);

      // 7: remaining ALU operations with a negative operand
      prog = {ri(ADDI, 1, 0, -3), ri(ADDI, 2, 0, 7), rr(MUL, 3, 1, 2), rr(SLT, 4, 1, 2),
              rr(SLT, 5, 2, 1), rr(AND_, 6, 1, 2), rr(OR_, 7, 1, 2), ri(SLTI, 8, 1, -2),
              ri(SUBI, 9, 2, 10), HLT_W};
      run_test("t7");
      chk("t7 MUL", dut.regs[3], 32'hFFFFFFEB);
      chk("t7 SLT", dut.regs[4], 32'd1);
      chk("t7 SLT rev", dut.regs[5], 32'd0);
      chk("t7 AND", dut.regs[6], 32'd5);
      chk("t7 OR", dut.regs[7], 32'hFFFFFFFF);
      chk("t7 SLTI", dut.regs[8], 32'd1);
      chk("t7 SUBI", dut.regs[9], 32'hFFFFFFFD);

      // 6: asynchronous reset mid-run, then rerun to completion
      load_t1();
      rst_n = 1'b0;
      #1;
      load_prog();
      model_run();
      @(negedge clk);
      rst_n = 1'b1;
      run_edges("t6pre", 6);
      chk("t6 R1 before reset", dut.regs[1], 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 async pc", 32'(pc), 32'd0);
      chk("t6 async halted", 32'(halted), 32'd0);
      chk("t6 async R1", dut.regs[1], 32'd0);
      chk("t6 async R2", dut.regs[2], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_edges("t6", model_h + 3);
      check_final("t6");
      chk("t6 R5", dut.regs[5], 32'd55);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
